ff_cmd_driver: RTL

//  Command-side driver for a bank of WIDTH two-input command flip-flops.
//  Per-bit code {B1,B2}: 00 hold, 01 clear (Q<=0), 10 toggle (Q<=~Q), 11 set (Q<=1).

---
 rtl/ff_cmd_driver.sv | 105 ++++++++++
 1 files changed

// File: rtl/ff_cmd_driver.sv
// Drives B1/B2 command codes into a bank of two-input flip-flops so the bank reaches a
// requested word, verifies the result through q_fb and re-issues forced set/clear codes on mismatch.
module ff_cmd_driver #(
  parameter int WIDTH     = 8,
  parameter int MAX_RETRY = 2,
  localparam int RW       = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_target,
  input  logic             req_mode,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] B1,
  output logic [WIDTH-1:0] B2,
  output logic             done,
  output logic             err,
  output logic [RW-1:0]    retries
);

  typedef enum logic [1:0] {IDLE, ISSUE, CHECK} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic [WIDTH-1:0] b1_d, b2_d;
  logic [RW-1:0]    cnt_q, cnt_d, retries_d;
  logic             done_d, err_d;

  // Set (11) where the target is 1, clear (01) elsewhere: result is independent of current Q.
  function automatic logic [2*WIDTH-1:0] explicit_codes(input logic [WIDTH-1:0] tgt);
    return {tgt, {WIDTH{1'b1}}};
  endfunction

  // Toggle (10) only the bits that differ, hold (00) the rest.
  function automatic logic [2*WIDTH-1:0] toggle_codes(input logic [WIDTH-1:0] tgt,
                                                      input logic [WIDTH-1:0] q);
    return {tgt ^ q, {WIDTH{1'b0}}};
  endfunction

  always_comb begin
    state_d   = state_q;
    tgt_d     = tgt_q;
    cnt_d     = cnt_q;
    b1_d      = '0;
    b2_d      = '0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    retries_d = retries;
    req_ready = (state_q == IDLE);
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          tgt_d   = req_target;
          cnt_d   = '0;
          state_d = ISSUE;
          if (req_mode) {b1_d, b2_d} = explicit_codes(req_target);
          else          {b1_d, b2_d} = toggle_codes(req_target, q_fb);
        end
      end
      ISSUE: state_d = CHECK;
      CHECK: begin
        if (q_fb == tgt_q) begin
          done_d    = 1'b1;
          retries_d = cnt_q;
          state_d   = IDLE;
        end else if (cnt_q < RW'(MAX_RETRY)) begin
          cnt_d        = cnt_q + RW'(1);
          {b1_d, b2_d} = explicit_codes(tgt_q);
          state_d      = ISSUE;
        end else begin
          done_d    = 1'b1;
          err_d     = 1'b1;
          retries_d = cnt_q;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered state and outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tgt_q   <= '0;
      cnt_q   <= '0;
      B1      <= '0;
      B2      <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
      retries <= '0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      B1      <= b1_d;
      B2      <= b2_d;
      done    <= done_d;
      err     <= err_d;
      retries <= retries_d;
    end
  end

endmodule
